// File: rtl/ts_rec_pkg.sv
// Shared types and constants for the TS recorder: FSM states, slot
// geometry, DDR word field layout and the word packing helper.
package ts_rec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  localparam int TS_W   = 10;  // {VALID, SYNC, DATA[7:0]}
  localparam int SLOTS  = 3;
  localparam int CNT_W  = 2;   // holds 0..SLOTS
  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;
  localparam int WCNT_W = 25;  // one more bit than the address, so a full memory fits

  // DDR word layout
  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 10;
  localparam int SLOT2_LSB = 20;
  localparam int CNT_LSB   = 30;

  localparam logic [ADDR_W-1:0] DEF_END_ADDR = 24'hFFFFFF;

  // Build a DDR word from the slot registers and the filled-slot count.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [SLOTS-1:0][TS_W-1:0] slots,
    input logic [CNT_W-1:0]           cnt
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[SLOT0_LSB +: TS_W]  = slots[0];
    w[SLOT1_LSB +: TS_W]  = slots[1];
    w[SLOT2_LSB +: TS_W]  = slots[2];
    w[CNT_LSB   +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/ts_slot_packer.sv
// Three-slot accumulator: stores TS entries in arrival order (slot0 first)
// and presents them as one packed DDR word with the filled-slot count.
module ts_slot_packer
  import ts_rec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,   // store din_i in the next free slot
  input  logic              clear_i,  // empty all slots; wins over load_i
  input  logic [TS_W-1:0]   din_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic [WORD_W-1:0] word_o
);

  logic [SLOTS-1:0][TS_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]           cnt_q,  cnt_d;

  // Next-state: clear zeroes unused slots so a partial word carries zeros.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      slot_d = '0;
      cnt_d  = '0;
    end else if (load_i && !full_o) begin
      slot_d[cnt_q] = din_i;
      cnt_d         = cnt_q + CNT_W'(1);
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(SLOTS));
  assign word_o  = pack_word(slot_q, cnt_q);

endmodule

// File: rtl/ts_ddr_write_packer.sv
// Transport-stream recorder write side: pulls 10-bit entries from the TS
// FIFO, packs three per 32-bit word and writes them sequentially to DDR
// over an Avalon-MM write master, stopping on STOP or at END_ADDR.
module ts_ddr_write_packer
  import ts_rec_pkg::*;
#(
  parameter logic [ADDR_W-1:0] END_ADDR = DEF_END_ADDR
) (
  input  logic              SYS_CLOCK,
  input  logic              SYS_RESET_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              FIFO_EMPTY,
  input  logic [TS_W-1:0]   FIFO_Q,
  output logic              FIFO_RDREQ,
  output logic [ADDR_W-1:0] ddr_write_address,
  output logic              ddr_write_write,
  output logic [WORD_W-1:0] ddr_write_writedata,
  output logic [3:0]        ddr_write_byteenable,
  input  logic              ddr_write_waitrequest,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_FULL,
  output logic [WCNT_W-1:0] WORD_COUNT
);

  state_e              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;     // FIFO read issued last cycle
  logic                stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                full_q, full_d;

  logic                slot_load, slot_clear, slot_full;
  logic [CNT_W-1:0]    slot_cnt;
  logic [WORD_W-1:0]   slot_word;
  logic                rdreq, wr, done;

  ts_slot_packer u_slots (
    .clk_i   (SYS_CLOCK),
    .rst_ni  (SYS_RESET_N),
    .load_i  (slot_load),
    .clear_i (slot_clear),
    .din_i   (FIFO_Q),
    .count_o (slot_cnt),
    .full_o  (slot_full),
    .word_o  (slot_word)
  );

  // FSM next-state and outputs. A read is captured the cycle after
  // FIFO_RDREQ, and no new read is issued in that capture cycle, so at most
  // one read is in flight.
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = 1'b0;
    stop_pend_d = stop_pend_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    full_d      = full_q;
    slot_load   = 1'b0;
    slot_clear  = 1'b0;
    rdreq       = 1'b0;
    wr          = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // STOP alone is ignored; START wins when both arrive together.
        if (START) begin
          addr_d      = '0;
          wcnt_d      = '0;
          full_d      = 1'b0;
          stop_pend_d = 1'b0;
          slot_clear  = 1'b1;
          state_d     = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (STOP) stop_pend_d = 1'b1;
        if (rd_pend_q) begin
          // In-flight read is always captured, even after a stop.
          slot_load = 1'b1;
          if (slot_cnt == CNT_W'(SLOTS-1)) state_d = ST_WRITE;
        end else if (stop_pend_q) begin
          state_d = (slot_cnt != '0) ? ST_WRITE : ST_FINISH;
        end else if (!FIFO_EMPTY && !slot_full) begin
          rdreq     = 1'b1;
          rd_pend_d = 1'b1;
        end
      end
      ST_WRITE: begin
        wr = 1'b1;
        if (STOP) stop_pend_d = 1'b1;
        if (!ddr_write_waitrequest) begin
          slot_clear = 1'b1;
          wcnt_d     = wcnt_q + WCNT_W'(1);
          if (addr_q == END_ADDR) begin
            // Address is left at END_ADDR; it never wraps.
            full_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = stop_pend_q ? ST_FINISH : ST_COLLECT;
          end
        end
      end
      ST_FINISH: begin
        done        = 1'b1;
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and bookkeeping registers.
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      stop_pend_q <= stop_pend_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      full_q      <= full_d;
    end
  end

  // Outputs decode from state, so reset clears them without waiting for a clock.
  assign FIFO_RDREQ           = rdreq;
  assign ddr_write_write      = wr;
  assign ddr_write_address    = addr_q;
  assign ddr_write_writedata  = slot_word;
  assign ddr_write_byteenable = 4'hF;
  assign BUSY                 = (state_q != ST_IDLE);
  assign DONE                 = done;
  assign MEM_FULL             = full_q;
  assign WORD_COUNT           = wcnt_q;

endmodule

// File: tb/tb_ts_ddr_write_packer.sv
// Scoreboard bench: expected DDR writes are queued as FIFO entries are
// loaded, accepted writes are collected at the negedge and compared in order.
module tb_ts_ddr_write_packer;

  localparam logic [23:0] TB_END = 24'h000003;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, fifo_empty, rdreq, wr, waitreq;
  logic        busy, done, mem_full;
  logic [9:0]  fifo_q;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [24:0] wcnt;

  always #10 clk = ~clk;

  ts_ddr_write_packer #(.END_ADDR(TB_END)) dut (
    .SYS_CLOCK             (clk),
    .SYS_RESET_N           (rst_n),
    .START                 (start),
    .STOP                  (stop),
    .FIFO_EMPTY            (fifo_empty),
    .FIFO_Q                (fifo_q),
    .FIFO_RDREQ            (rdreq),
    .ddr_write_address     (addr),
    .ddr_write_write       (wr),
    .ddr_write_writedata   (wdata),
    .ddr_write_byteenable  (be),
    .ddr_write_waitrequest (waitreq),
    .BUSY                  (busy),
    .DONE                  (done),
    .MEM_FULL              (mem_full),
    .WORD_COUNT            (wcnt)
  );

  // FIFO model: data appears the cycle after a read request.
  logic [9:0] fmem [0:1023];
  int         wp = 0;
  int         rp = 0;
  logic       flush = 1'b0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (rdreq && (rp != wp)) begin
      fifo_q <= fmem[rp[9:0]];
      rp     <= rp + 1;
    end
  end

  // Scoreboard queues: {addr, data}.
  logic [55:0] exp_q[$];
  logic [55:0] acc_q[$];

  always @(negedge clk)
    if (rst_n && wr && !waitreq) acc_q.push_back({addr, wdata});

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] c, input logic [9:0] e0,
                                     input logic [9:0] e1, input logic [9:0] e2);
    return {c, e2, e1, e0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] e);
    fmem[wp[9:0]] = e;
    wp++;
  endtask

  task automatic exp_wr(input logic [23:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  // Wait up to lim negedges for DONE, then require it to be a single-cycle pulse.
  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_wr(input string tag, input int lim);
    int n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (wr) break;
    end
    chk({tag, "_wr_seen"}, 64'(wr), 64'd1);
  endtask

  task automatic wait_wcnt(input string tag, input logic [24:0] v, input int lim);
    int n = 0;
    while (n < lim && wcnt != v) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wcnt"}, 64'(wcnt), 64'(v));
  endtask

  // Compare collected writes against expectations, in order.
  task automatic drain(input string tag);
    chk({tag, "_nwrites"}, 64'(acc_q.size()), 64'(exp_q.size()));
    while (acc_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_addr_data"}, 64'(acc_q.pop_front()), 64'(exp_q.pop_front()));
    acc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] e [0:14];
    logic [23:0] a0;
    logic [31:0] d0;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; waitreq = 1'b0;
    #35;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_rdreq", 64'(rdreq), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_full", 64'(mem_full), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wcnt", 64'(wcnt), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_be", 64'(be), 64'hF);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(2);

    // Six entries -> two full words, then stop with nothing buffered.
    e[0] = 10'h247; e[1] = 10'h212; e[2] = 10'h334;
    e[3] = 10'h1A5; e[4] = 10'h3FF; e[5] = 10'h080;
    for (int i = 0; i < 6; i++) push(e[i]);
    exp_wr(24'd0, mk(2'd3, e[0], e[1], e[2]));
    exp_wr(24'd1, mk(2'd3, e[3], e[4], e[5]));
    pulse_start();
    wait_wcnt("six", 25'd2, 100);
    pulse_stop();
    wait_done("six", 10);
    drain("six");
    cyc(3);
    chk("six_wcnt_hold", 64'(wcnt), 64'd2);
    chk("six_rdreq_idle", 64'(rdreq), 64'd0);

    // Four entries then STOP -> one full and one partial word.
    e[0] = 10'h155; e[1] = 10'h2AA; e[2] = 10'h0F0; e[3] = 10'h301;
    for (int i = 0; i < 4; i++) push(e[i]);
    exp_wr(24'd0, mk(2'd3, e[0], e[1], e[2]));
    exp_wr(24'd1, mk(2'd1, e[3], 10'h0, 10'h0));
    pulse_start();
    for (int n = 0; n < 100 && wp != rp; n++) @(negedge clk);
    cyc(4);
    pulse_stop();
    wait_done("part", 10);
    drain("part");
    chk("part_wcnt", 64'(wcnt), 64'd2);

    // Waitrequest held high for five cycles during a write.
    waitreq = 1'b1;
    e[0] = 10'h111; e[1] = 10'h222; e[2] = 10'h333;
    for (int i = 0; i < 3; i++) push(e[i]);
    exp_wr(24'd0, mk(2'd3, e[0], e[1], e[2]));
    pulse_start();
    wait_wr("wait", 50);
    a0 = addr; d0 = wdata;
    chk("wait_first_data", 64'(d0), 64'(mk(2'd3, e[0], e[1], e[2])));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_hold_wr", 64'(wr), 64'd1);
      chk("wait_hold_ad", 64'({addr, wdata}), 64'({a0, d0}));
    end
    @(posedge clk); #1 waitreq = 1'b0;
    @(negedge clk);
    chk("wait_last_wr", 64'(wr), 64'd1);
    chk("wait_last_ad", 64'({addr, wdata}), 64'({a0, d0}));
    @(negedge clk);
    chk("wait_wr_drop", 64'(wr), 64'd0);
    pulse_stop();
    wait_done("wait", 10);
    drain("wait");
    chk("wait_wcnt", 64'(wcnt), 64'd1);

    // Continuous data with END_ADDR = 3 -> exactly four writes, then full.
    for (int i = 0; i < 15; i++) begin
      e[i] = 10'((i * 37 + 5) & 10'h3FF);
      push(e[i]);
    end
    for (int w = 0; w < 4; w++)
      exp_wr(24'(w), mk(2'd3, e[3*w], e[3*w+1], e[3*w+2]));
    pulse_start();
    wait_done("full", 200);
    chk("full_flag", 64'(mem_full), 64'd1);
    chk("full_wcnt", 64'(wcnt), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_no_rdreq", 64'(rdreq), 64'd0);
    end
    chk("full_left_in_fifo", 64'(wp - rp), 64'd3);
    drain("full");
    chk("full_flag_hold", 64'(mem_full), 64'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // STOP with empty FIFO and no buffered slots -> no write, quick DONE.
    pulse_start();
    chk("empty_full_clr", 64'(mem_full), 64'd0);
    cyc(3);
    pulse_stop();
    wait_done("empty", 2);
    chk("empty_wcnt", 64'(wcnt), 64'd0);
    drain("empty");

    // Reset in the middle of a stalled write, then a clean recording.
    waitreq = 1'b1;
    e[0] = 10'h3C1; e[1] = 10'h0A2; e[2] = 10'h213;
    for (int i = 0; i < 3; i++) push(e[i]);
    pulse_start();
    wait_wr("rst", 50);
    #5 rst_n = 1'b0;
    #1;
    chk("rstw_wr", 64'(wr), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_addr", 64'(addr), 64'd0);
    chk("rstw_rdreq", 64'(rdreq), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; waitreq = 1'b0;
    e[0] = 10'h045; e[1] = 10'h2B6; e[2] = 10'h1E7;
    for (int i = 0; i < 3; i++) push(e[i]);
    exp_wr(24'd0, mk(2'd3, e[0], e[1], e[2]));
    pulse_start();
    wait_wcnt("rstw", 25'd1, 100);
    pulse_stop();
    wait_done("rstw", 10);
    drain("rstw");

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
